// File: rtl/op_sequencer_if.sv
// Command and control bundle between the op_sequencer and its neighbours.
// The slave modport is the sequencer's view, and the master modport is the driver's view.
interface op_sequencer_if #(
    parameter int DEPTH = 4
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             LoadA;
    logic             LoadB;
    logic             Cmd_Valid;
    logic [2:0]       Cmd_F;
    logic [1:0]       Cmd_R;
    logic             Cmd_Ready;
    logic             Ld_A;
    logic             Ld_B;
    logic             Shift_En;
    logic [2:0]       F_out;
    logic [1:0]       R_out;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Count;

    modport slave (
        input  LoadA, LoadB, Cmd_Valid, Cmd_F, Cmd_R,
        output Cmd_Ready, Ld_A, Ld_B, Shift_En, F_out, R_out, Busy, Done, Count
    );

    modport master (
        output LoadA, LoadB, Cmd_Valid, Cmd_F, Cmd_R,
        input  Cmd_Ready, Ld_A, Ld_B, Shift_En, F_out, R_out, Busy, Done, Count
    );
endinterface

// File: rtl/op_sequencer.sv
// Command-queue scheduler for the 8-bit logic processor datapath.
// {F,R} commands are queued, then issued one at a time as a WIDTH-cycle shift pass.
// Register-load requests take priority over issue, but only while the sequencer is idle.
module op_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    op_sequencer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SHF_W = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [SHF_W-1:0] WIDTH_C = SHF_W'(WIDTH);
    localparam logic [SHF_W-1:0] SHF_ONE = SHF_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [4:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [SHF_W-1:0] shift_cnt_reg;
    logic             load_a_prev_reg;
    logic             load_b_prev_reg;
    logic             ld_a_reg;
    logic             ld_b_reg;
    logic             shift_en_reg;
    logic             done_reg;
    logic [2:0]       f_reg;
    logic [1:0]       r_reg;

    logic cmd_ready;
    logic push;
    logic pop;
    logic load_a_edge;
    logic load_b_edge;

    // Ready looks only at the registered occupancy, so a pop cannot open a slot in the same cycle.
    assign cmd_ready   = (count_reg < DEPTH_C);
    assign push        = bus.Cmd_Valid & cmd_ready;
    assign load_a_edge = bus.LoadA & ~load_a_prev_reg;
    assign load_b_edge = bus.LoadB & ~load_b_prev_reg;
    // A pending load edge blocks issue for this cycle.
    assign pop         = (state_reg == IDLE) & ~load_a_edge & ~load_b_edge & (count_reg != '0);

    // Queue storage. This block is write-only, and the head is read into the F/R registers at pop.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {bus.Cmd_F, bus.Cmd_R};
        end
    end

    // Queue pointers and occupancy. The pointers wrap modulo DEPTH.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sequencer FSM. This block also holds the registered strobes, the selects and the load-edge history.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg       <= IDLE;
            shift_cnt_reg   <= '0;
            load_a_prev_reg <= 1'b0;
            load_b_prev_reg <= 1'b0;
            ld_a_reg        <= 1'b0;
            ld_b_reg        <= 1'b0;
            shift_en_reg    <= 1'b0;
            done_reg        <= 1'b0;
            f_reg           <= '0;
            r_reg           <= '0;
        end else begin
            load_a_prev_reg <= bus.LoadA;
            load_b_prev_reg <= bus.LoadB;
            ld_a_reg        <= 1'b0;
            ld_b_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    ld_a_reg <= load_a_edge;
                    ld_b_reg <= load_b_edge;
                    if (pop) begin
                        f_reg         <= mem[rd_ptr_reg][4:2];
                        r_reg         <= mem[rd_ptr_reg][1:0];
                        shift_cnt_reg <= WIDTH_C;
                        shift_en_reg  <= 1'b1;
                        state_reg     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_cnt_reg <= shift_cnt_reg - SHF_ONE;
                    if (shift_cnt_reg == SHF_ONE) begin
                        shift_en_reg <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    shift_en_reg <= 1'b0;
                    done_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    // Output drive.
    assign bus.Cmd_Ready = cmd_ready;
    assign bus.Ld_A      = ld_a_reg;
    assign bus.Ld_B      = ld_b_reg;
    assign bus.Shift_En  = shift_en_reg;
    assign bus.F_out     = f_reg;
    assign bus.R_out     = r_reg;
    assign bus.Done      = done_reg;
    assign bus.Count     = count_reg;
    assign bus.Busy      = (state_reg != IDLE) | (count_reg != '0);
endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer. Two configurations run side by side on shared stimulus:
// WIDTH=8/DEPTH=4 and WIDTH=4/DEPTH=2.
`timescale 1ns/1ps
module tb_op_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       load_a;
    logic       load_b;
    logic       cmd_valid;
    logic [2:0] cmd_f;
    logic [1:0] cmd_r;

    int n_checks = 0;
    int n_fail   = 0;

    logic       shift_o [2];
    logic       done_o  [2];
    logic       busy_o  [2];
    logic       ready_o [2];
    logic       ld_a_o  [2];
    logic       ld_b_o  [2];
    logic [2:0] f_o     [2];
    logic [1:0] r_o     [2];
    logic [2:0] cnt_o   [2];

    task automatic check(input string name, input int cfg, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", cfg, name, act, exp, $time);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : cfg
            localparam int W = (gi == 0) ? 8 : 4;
            localparam int D = (gi == 0) ? 4 : 2;

            op_sequencer_if #(.DEPTH(D)) bus ();

            assign bus.LoadA     = load_a;
            assign bus.LoadB     = load_b;
            assign bus.Cmd_Valid = cmd_valid;
            assign bus.Cmd_F     = cmd_f;
            assign bus.Cmd_R     = cmd_r;

            op_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
                .Clk     (clk),
                .Reset_n (rst_n),
                .bus     (bus)
            );

            assign shift_o[gi] = bus.Shift_En;
            assign done_o[gi]  = bus.Done;
            assign busy_o[gi]  = bus.Busy;
            assign ready_o[gi] = bus.Cmd_Ready;
            assign ld_a_o[gi]  = bus.Ld_A;
            assign ld_b_o[gi]  = bus.Ld_B;
            assign f_o[gi]     = bus.F_out;
            assign r_o[gi]     = bus.R_out;
            assign cnt_o[gi]   = 3'(bus.Count);

            // Reference model. The queue is an SV queue, and each issued op has a lifetime
            // of W shift cycles plus one Done cycle, counted down in life_left.
            logic [4:0] q[$];
            int         life_left = 0;
            logic [2:0] m_f = '0;
            logic [1:0] m_r = '0;
            logic       m_ld_a = 1'b0;
            logic       m_ld_b = 1'b0;
            logic       m_prev_a = 1'b0;
            logic       m_prev_b = 1'b0;

            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q.delete();
                    life_left = 0;
                    m_f = '0;
                    m_r = '0;
                    m_ld_a = 1'b0;
                    m_ld_b = 1'b0;
                    m_prev_a = 1'b0;
                    m_prev_b = 1'b0;
                end else begin
                    automatic int occ  = q.size();
                    automatic bit idle = (life_left == 0);
                    automatic bit ea   = load_a && !m_prev_a;
                    automatic bit eb   = load_b && !m_prev_b;
                    automatic bit acc  = cmd_valid && (occ < D);
                    // A load edge seen while idle produces a strobe in the following cycle.
                    m_ld_a = idle && ea;
                    m_ld_b = idle && eb;
                    if (idle && !ea && !eb && occ != 0) begin
                        {m_f, m_r} = q.pop_front();
                        life_left  = W + 1;
                    end else if (life_left > 0) begin
                        life_left--;
                    end
                    if (acc) q.push_back({cmd_f, cmd_r});
                    m_prev_a = load_a;
                    m_prev_b = load_b;
                end
            end

            // Compare every cycle, away from the active edge.
            always @(negedge clk) begin
                check("Shift_En",  gi, int'(shift_o[gi]), int'(life_left > 1));
                check("Done",      gi, int'(done_o[gi]),  int'(life_left == 1));
                check("Busy",      gi, int'(busy_o[gi]),  int'(life_left != 0 || q.size() != 0));
                check("Cmd_Ready", gi, int'(ready_o[gi]), int'(q.size() < D));
                check("Count",     gi, int'(cnt_o[gi]),   q.size());
                check("Ld_A",      gi, int'(ld_a_o[gi]),  int'(m_ld_a));
                check("Ld_B",      gi, int'(ld_b_o[gi]),  int'(m_ld_b));
                check("F_out",     gi, int'(f_o[gi]),     int'(m_f));
                check("R_out",     gi, int'(r_o[gi]),     int'(m_r));
            end
        end
    endgenerate

    // Wait (bounded) at negedges until cfg0 Shift_En (sel=0) or Done (sel=1) is high.
    task automatic wait_cfg0(input int sel, input string name);
        int n;
        n = 0;
        while (!((sel == 0) ? shift_o[0] : done_o[0]) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 0, int'(n < 60), 1);
    endtask

    initial begin
        int s0, d0, s1, d1, lda;
        rst_n = 1'b0; load_a = 1'b0; load_b = 1'b0;
        cmd_valid = 1'b0; cmd_f = '0; cmd_r = '0;
        repeat (3) @(negedge clk);
        check("reset.Cmd_Ready", 0, int'(ready_o[0]), 1);
        check("reset.Busy",      0, int'(busy_o[0]),  0);
        check("reset.Count",     0, int'(cnt_o[0]),   0);
        check("reset.Shift_En",  0, int'(shift_o[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op: {F=010,R=01}. k counts cycles after the accepting edge.
        cmd_valid = 1'b1; cmd_f = 3'b010; cmd_r = 2'b01;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            check("t1.Shift_En", 0, int'(shift_o[0]), int'(k >= 2 && k <= 9));
            check("t1.Done",     0, int'(done_o[0]),  int'(k == 10));
            check("t1.Busy",     0, int'(busy_o[0]),  int'(k <= 10));
            check("t1.Shift_En", 1, int'(shift_o[1]), int'(k >= 2 && k <= 5));
            check("t1.Done",     1, int'(done_o[1]),  int'(k == 6));
            if (k >= 2) begin
                check("t1.F_out", 0, int'(f_o[0]), 2);
                check("t1.R_out", 0, int'(r_o[0]), 1);
            end
        end

        // Cmd_Valid held for 6 edges: cfg0 accepts 5 (one pop frees a slot), and cfg1 accepts 3.
        s0 = 0; d0 = 0; s1 = 0; d1 = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_f = 3'($urandom); cmd_r = 2'($urandom);
            @(negedge clk);
            s0 += int'(shift_o[0]); d0 += int'(done_o[0]);
            s1 += int'(shift_o[1]); d1 += int'(done_o[1]);
        end
        cmd_valid = 1'b0;
        check("t2.Count",     0, int'(cnt_o[0]),   4);
        check("t2.Cmd_Ready", 0, int'(ready_o[0]), 0);
        check("t2.Count",     1, int'(cnt_o[1]),   2);
        check("t2.Cmd_Ready", 1, int'(ready_o[1]), 0);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            s0 += int'(shift_o[0]); d0 += int'(done_o[0]);
            s1 += int'(shift_o[1]); d1 += int'(done_o[1]);
        end
        check("t2.shift_total", 0, s0, 40);
        check("t2.done_total",  0, d0, 5);
        check("t2.shift_total", 1, s1, 12);
        check("t2.done_total",  1, d1, 3);

        // LoadA and LoadB rise together in idle with two commands queued.
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        wait_cfg0(1, "t4.wait_done");
        @(negedge clk);
        load_a = 1'b1; load_b = 1'b1;
        @(negedge clk);
        check("t4.Ld_A",     0, int'(ld_a_o[0]),  1);
        check("t4.Ld_B",     0, int'(ld_b_o[0]),  1);
        check("t4.Count",    0, int'(cnt_o[0]),   2);
        check("t4.Shift_En", 0, int'(shift_o[0]), 0);
        @(negedge clk);
        check("t4.Ld_A_off", 0, int'(ld_a_o[0]),  0);
        check("t4.Count",    0, int'(cnt_o[0]),   1);
        check("t4.Shift_En", 0, int'(shift_o[0]), 1);
        repeat (2) @(negedge clk);
        load_a = 1'b0; load_b = 1'b0;
        repeat (40) @(negedge clk);

        // LoadA rises during SHIFT and is held past Done. A fresh edge in idle gives one strobe.
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_cfg0(0, "t3.wait_shift");
        load_a = 1'b1;
        lda = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            lda += int'(ld_a_o[0]);
        end
        check("t3.no_Ld_A", 0, lda, 0);
        load_a = 1'b0;
        @(negedge clk);
        load_a = 1'b1;
        lda = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lda += int'(ld_a_o[0]);
        end
        check("t3.one_Ld_A", 0, lda, 1);
        load_a = 1'b0;
        repeat (3) @(negedge clk);

        // Reset asserted during the 4th shift cycle of cfg0.
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        wait_cfg0(0, "t5.wait_shift");
        repeat (3) @(negedge clk);
        check("t5.pre_Shift_En", 0, int'(shift_o[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5.Shift_En",  0, int'(shift_o[0]), 0);
        check("t5.Count",     0, int'(cnt_o[0]),   0);
        check("t5.Cmd_Ready", 0, int'(ready_o[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            s0 += int'(shift_o[0]) + int'(shift_o[1]);
        end
        check("t5.no_shift_after", 0, s0, 0);

        // Randomized traffic, alternating dense and sparse phases, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (((i / 500) % 2) == 0) cmd_valid = ($urandom_range(0, 2) == 0);
            else                      cmd_valid = ($urandom_range(0, 15) == 0);
            cmd_f = 3'($urandom);
            cmd_r = 2'($urandom);
            if ($urandom_range(0, 9) == 0) load_a = ~load_a;
            if ($urandom_range(0, 9) == 0) load_b = ~load_b;
            rst_n = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
